// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line, baud tick and parallel result bundle for the UART receiver
interface uart_receiver_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx;
   logic                  tick;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rx_done;
   logic                  frame_err;
   logic                  rx_busy;

   // driver side: pad line and baud generator in, received word out
   modport master (
      output rx,
      output tick,
      input  data_out,
      input  rx_done,
      input  frame_err,
      input  rx_busy
   );

   // receiver side
   modport slave (
      input  rx,
      input  tick,
      output data_out,
      output rx_done,
      output frame_err,
      output rx_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver, LSB first, no parity, one stop bit
module uart_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   uart_receiver_if.slave  bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH) + 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic [1:0]             state;
   logic [CW-1:0]          sample_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_WIDTH-1:0]  shift;
   logic [DATA_WIDTH-1:0]  data_q;
   logic                   done_q;
   logic                   err_q;

   // metastability synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.rx};
      end
   end

   assign rx_s = sync[SYNC_STAGES-1];

   // frame FSM: start validation at half bit, then one sample per full bit period
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               // falling edge is taken immediately, independent of tick
               if (!rx_s) begin
                  state      <= START;
                  sample_cnt <= '0;
               end
            end
            START: begin
               if (bus.tick) begin
                  if (sample_cnt == HALF_LAST) begin
                     if (!rx_s) begin
                        state      <= DATA;
                        sample_cnt <= '0;
                        bit_cnt    <= '0;
                     end else begin
                        // line bounced back high before mid start bit: glitch
                        state <= IDLE;
                     end
                  end else begin
                     sample_cnt <= sample_cnt + CW'(1);
                  end
               end
            end
            DATA: begin
               if (bus.tick) begin
                  if (sample_cnt == FULL_LAST) begin
                     shift      <= {rx_s, shift[DATA_WIDTH-1:1]};
                     sample_cnt <= '0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end else begin
                     sample_cnt <= sample_cnt + CW'(1);
                  end
               end
            end
            STOP: begin
               if (bus.tick) begin
                  if (sample_cnt == FULL_LAST) begin
                     // errored frames still publish their word; frame_err qualifies it
                     data_q     <= shift;
                     err_q      <= ~rx_s;
                     done_q     <= 1'b1;
                     sample_cnt <= '0;
                     state      <= IDLE;
                  end else begin
                     sample_cnt <= sample_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_out  = data_q;
   assign bus.rx_done   = done_q;
   assign bus.frame_err = err_q;
   assign bus.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;
   localparam int NOM = 64;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         bit_clk;
      int         gap;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   tcnt;
   logic [7:0] last_data;
   logic       prev_done;
   exp_t       q[$];
   vec_t       vecs[8];

   uart_receiver_if #(.DATA_WIDTH(8)) bus ();

   uart_receiver #(
      .DATA_WIDTH (8),
      .OVERSAMPLE (16),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one tick every 4 clocks: 16 ticks = 64 clk per nominal bit
   task automatic tick_gen();
      forever begin
         @(posedge clk);
         #1;
         bus.tick = (tcnt == 3);
         tcnt = (tcnt + 1) % 4;
      end
   endtask

   // scoreboard: every rx_done must match the oldest expected frame
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (bus.rx_done === 1'b1) begin
            if (prev_done) check("done_width", 32'd2, 32'd1);
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("data_out", {24'd0, bus.data_out}, {24'd0, e.data});
               check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.err});
               last_data = e.data;
            end
         end
         prev_done = (bus.rx_done === 1'b1);
      end
   endtask

   // drive one frame; a low stop bit is kept short so the re-entered START
   // sees the line high again at its half-bit check
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_clk, input int gap);
      bus.rx = 1'b0;
      wait_clk(bit_clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         wait_clk(bit_clk);
      end
      if (stop) begin
         bus.rx = 1'b1;
         wait_clk(bit_clk);
      end else begin
         bus.rx = 1'b0;
         wait_clk(bit_clk / 2 + 8);
         bus.rx = 1'b1;
         wait_clk(bit_clk - bit_clk / 2 - 8);
      end
      wait_clk(gap);
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic err);
      exp_t e;
      e.data = d;
      e.err  = err;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && q.size() != 0; i++) wait_clk(1);
      check("drain", q.size(), 32'd0);
      wait_clk(80);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      tcnt      = 0;
      prev_done = 1'b0;
      last_data = 8'h00;
      bus.rx    = 1'b1;
      bus.tick  = 1'b0;
      rst       = 1'b1;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, bit_clk: NOM, gap: 40};
      vecs[1] = '{data: 8'h00, stop: 1'b1, bit_clk: NOM, gap: 0};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, bit_clk: NOM, gap: 0};
      vecs[3] = '{data: 8'h01, stop: 1'b1, bit_clk: NOM, gap: 0};
      vecs[4] = '{data: 8'h80, stop: 1'b1, bit_clk: NOM, gap: 40};
      vecs[5] = '{data: 8'h5A, stop: 1'b0, bit_clk: NOM, gap: 64};
      vecs[6] = '{data: 8'h11, stop: 1'b1, bit_clk: NOM, gap: 20};
      vecs[7] = '{data: 8'h55, stop: 1'b1, bit_clk: 66,  gap: 40};

      fork
         tick_gen();
         monitor();
      join_none

      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);
      check("rst_data_out", {24'd0, bus.data_out}, 32'd0);
      check("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("rst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
      wait_clk(20);

      for (int i = 0; i < 8; i++) begin
         expect_frame(vecs[i].data, ~vecs[i].stop);
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_clk, vecs[i].gap);
         if (i == 0) begin
            drain();
            check("busy_after_a5", {31'd0, bus.rx_busy}, 32'd0);
         end
      end
      drain();

      // start glitch: three ticks low, then high
      bus.rx = 1'b0;
      wait_clk(12);
      bus.rx = 1'b1;
      wait_clk(80);
      check("glitch_idle", {31'd0, bus.rx_busy}, 32'd0);
      check("glitch_data_kept", {24'd0, bus.data_out}, {24'd0, last_data});
      expect_frame(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b1, NOM, 20);
      drain();

      // reset in the middle of the data bits of 0xC3
      bus.rx = 1'b0;
      wait_clk(NOM);
      for (int i = 0; i < 3; i++) begin
         bus.rx = (i < 2);
         wait_clk(NOM);
      end
      check("busy_mid_frame", {31'd0, bus.rx_busy}, 32'd1);
      rst    = 1'b1;
      bus.rx = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      check("midrst_data_out", {24'd0, bus.data_out}, 32'd0);
      check("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      check("midrst_rx_busy", {31'd0, bus.rx_busy}, 32'd0);
      check("midrst_rx_done", {31'd0, bus.rx_done}, 32'd0);
      wait_clk(2 * NOM);
      expect_frame(8'h96, 1'b0);
      send_frame(8'h96, 1'b1, NOM, 20);
      drain();

      // line break: one errored all-zero frame, then a glitch exit once the line returns high
      expect_frame(8'h00, 1'b1);
      bus.rx = 1'b0;
      wait_clk(620);
      bus.rx = 1'b1;
      wait_clk(100);
      drain();
      check("break_idle", {31'd0, bus.rx_busy}, 32'd0);

      // randomized frames against the frame-level model
      for (int i = 0; i < 16; i++) begin
         logic [7:0] d;
         logic       s;
         int         g;
         d = 8'($urandom_range(0, 255));
         s = ($urandom_range(0, 3) != 0);
         g = s ? int'($urandom_range(0, 40)) : 64 + int'($urandom_range(0, 20));
         expect_frame(d, ~s);
         send_frame(d, s, NOM, g);
      end
      drain();
      check("final_idle", {31'd0, bus.rx_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
